// File: rtl/matvec_mul_fold_pkg.sv
// Shared types and width helpers for the column-folded matrix-vector multiplier.
// The flag struct travels beside the data through every pipeline stage.
package matvec_pkg;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic sgn;
  } flags_t;

  function automatic int w_m(input int w_x, input int w_k);
    return w_x + w_k;
  endfunction

  // Wide enough for the sum of c full-width products.
  function automatic int w_y(input int w_x, input int w_k, input int c);
    return w_x + w_k + $clog2(c);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit cfg_legal(input int r, input int c, input int p,
                                   input int w_x, input int w_k);
    return (r > 0) && (w_x > 0) && (w_k > 0) && is_pow2(p) && (c >= p) && ((c % p) == 0);
  endfunction

endpackage

// File: rtl/matvec_mul_fold_adder_tree.sv
// P-input adder tree with one register per level and a shared hold enable.
// Internal nodes use heap numbering: node i sums nodes 2i and 2i+1; leaves are P..2P-1.
module mv_adder_tree
  import matvec_pkg::*;
#(
  parameter int P = 4,
  parameter int W = 19
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [P-1:0][W-1:0] in_data,
  input  flags_t              in_flags,
  output logic [W-1:0]        sum,
  output flags_t              out_flags
);

  localparam int DEPTH = $clog2(P);

  generate
    if (P == 1) begin : g_pass
      assign sum       = in_data[0];
      assign out_flags = in_flags;
    end else begin : g_tree
      logic [W-1:0] node_q [1:P-1];
      logic [W-1:0] node_d [1:P-1];
      logic [W-1:0] all_n  [1:2*P-1];
      flags_t       flag_q [1:DEPTH];
      flags_t       flag_d [1:DEPTH];

      // NOTE: every always_comb target is assigned on every path, so no latch can form.
      always_comb begin
        for (int j = 1; j < P; j++)     all_n[j] = node_q[j];
        for (int j = P; j < 2 * P; j++) all_n[j] = in_data[j-P];
        for (int i = 1; i < P; i++)
          node_d[i] = en ? (all_n[2*i] + all_n[2*i+1]) : node_q[i];
        flag_d[1] = en ? in_flags : flag_q[1];
        for (int l = 2; l <= DEPTH; l++)
          flag_d[l] = en ? flag_q[l-1] : flag_q[l];
      end

      // NOTE: datapath registers carry no reset; only the flags that qualify them do.
      always_ff @(posedge clk) begin
        node_q <= node_d;
      end

      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
        if (!rstn) flag_q <= '{default: '0};
        else       flag_q <= flag_d;
      end

      assign sum       = node_q[1];
      assign out_flags = flag_q[DEPTH];
    end
  endgenerate

endmodule

// File: rtl/matvec_mul_fold.sv
// Streaming column-folded matrix-vector multiplier y = K*x, P columns per beat.
// Pipeline: beat register, product register, per-row adder trees, accumulate/output.
module matvec_mul_fold
  import matvec_pkg::*;
#(
  parameter int R   = 8,
  parameter int C   = 8,
  parameter int P   = 4,
  parameter int W_X = 8,
  parameter int W_K = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [R*P*W_K-1:0]              s_k,
  input  logic [P*W_X-1:0]                s_x,
  input  logic                            s_signed,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [R*w_y(W_X, W_K, C)-1:0]   m_y
);

  localparam int BEATS = C / P;
  localparam int W_M   = w_m(W_X, W_K);
  localparam int W_Y   = w_y(W_X, W_K, C);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if (!cfg_legal(R, C, P, W_X, W_K)) begin : g_bad_cfg
      $error("matvec_mul_fold: P must be a power of two dividing C, widths positive");
    end
  endgenerate

  // Extend to W_M, multiply, then extend to W_Y; the mode picks sign or zero fill.
  function automatic logic [W_Y-1:0] mul_ext(input logic [W_X-1:0] x,
                                             input logic [W_K-1:0] k,
                                             input logic           sgn);
    logic [W_M-1:0] xe, ke, pm;
    xe = sgn ? W_M'($signed(x)) : W_M'(x);
    ke = sgn ? W_M'($signed(k)) : W_M'(k);
    pm = xe * ke;
    return sgn ? W_Y'($signed(pm)) : W_Y'(pm);
  endfunction

  logic adv, accept;

  logic [CNT_W-1:0]        beat_q, beat_d;
  logic                    sgn_q, sgn_d;
  flags_t                  beat_flags;
  flags_t                  in_f_q, in_f_d;
  logic [W_K-1:0]          in_k_q [R][P];
  logic [W_K-1:0]          in_k_d [R][P];
  logic [W_X-1:0]          in_x_q [P];
  logic [W_X-1:0]          in_x_d [P];
  flags_t                  prod_f_q, prod_f_d;
  logic [P-1:0][W_Y-1:0]   prod_q [R];
  logic [P-1:0][W_Y-1:0]   prod_d [R];
  logic [W_Y-1:0]          tree_sum [R];
  flags_t                  tree_f [R];
  flags_t                  acc_f;
  logic                    unused_flags;
  logic [W_Y-1:0]          row_sum [R];
  logic [W_Y-1:0]          acc_q [R];
  logic [W_Y-1:0]          acc_d [R];
  logic [W_Y-1:0]          m_y_q [R];
  logic [W_Y-1:0]          m_y_d [R];
  logic                    m_valid_q, m_valid_d;

  // The whole pipeline freezes only while a finished result is refused downstream.
  assign adv     = !(m_valid_q && !m_ready);
  assign s_ready = adv;
  assign accept  = s_valid && adv;

  always_comb begin
    beat_d = beat_q;
    sgn_d  = sgn_q;
    in_f_d = in_f_q;
    in_k_d = in_k_q;
    in_x_d = in_x_q;

    beat_flags.valid = accept;
    beat_flags.first = (beat_q == '0);
    beat_flags.last  = (beat_q == LAST_BEAT);
    beat_flags.sgn   = (beat_q == '0) ? s_signed : sgn_q;

    if (adv) begin
      in_f_d = beat_flags;
      for (int r = 0; r < R; r++)
        for (int p = 0; p < P; p++)
          in_k_d[r][p] = s_k[(r*P+p)*W_K +: W_K];
      for (int p = 0; p < P; p++)
        in_x_d[p] = s_x[p*W_X +: W_X];
    end

    if (accept) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + CNT_W'(1);
      sgn_d  = beat_flags.sgn;
    end
  end

  always_comb begin
    prod_f_d = adv ? in_f_q : prod_f_q;
    for (int r = 0; r < R; r++)
      for (int p = 0; p < P; p++)
        prod_d[r][p] = adv ? mul_ext(in_x_q[p], in_k_q[r][p], in_f_q.sgn) : prod_q[r][p];
  end

  generate
    for (genvar r = 0; r < R; r++) begin : g_row
      mv_adder_tree #(.P(P), .W(W_Y)) u_tree (
        .clk       (clk),
        .rstn      (rstn),
        .en        (adv),
        .in_data   (prod_q[r]),
        .in_flags  (prod_f_q),
        .sum       (tree_sum[r]),
        .out_flags (tree_f[r])
      );
    end
  endgenerate

  // All rows advance in lockstep, so row 0's flags stand for every row; the
  // other copies and the sign flag are deliberately left unused past this point.
  always_comb begin
    acc_f        = tree_f[0];
    unused_flags = acc_f.sgn;
    for (int r = 1; r < R; r++) unused_flags = unused_flags ^ (^tree_f[r]);
  end

  always_comb begin
    acc_d     = acc_q;
    m_y_d     = m_y_q;
    m_valid_d = m_valid_q;
    for (int r = 0; r < R; r++)
      row_sum[r] = (acc_f.first ? '0 : acc_q[r]) + tree_sum[r];

    if (adv) begin
      m_valid_d = acc_f.valid && acc_f.last;
      if (acc_f.valid) begin
        for (int r = 0; r < R; r++) begin
          if (acc_f.last) begin
            m_y_d[r] = row_sum[r];
            acc_d[r] = '0;
          end else begin
            acc_d[r] = row_sum[r];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    in_k_q <= in_k_d;
    in_x_q <= in_x_d;
    prod_q <= prod_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat_q    <= '0;
      sgn_q     <= 1'b0;
      in_f_q    <= '0;
      prod_f_q  <= '0;
      acc_q     <= '{default: '0};
      m_y_q     <= '{default: '0};
      m_valid_q <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      sgn_q     <= sgn_d;
      in_f_q    <= in_f_d;
      prod_f_q  <= prod_f_d;
      acc_q     <= acc_d;
      m_y_q     <= m_y_d;
      m_valid_q <= m_valid_d;
    end
  end

  always_comb begin
    m_y = '0;
    for (int r = 0; r < R; r++) m_y[r*W_Y +: W_Y] = m_y_q[r];
  end

  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_matvec_mul_fold.sv
// Scoreboard bench for matvec_mul_fold: a folded instance (P=4) and a single-beat one (P=C=8).
module tb_matvec_mul_fold;

  localparam int R     = 8;
  localparam int C     = 8;
  localparam int P     = 4;
  localparam int WX    = 8;
  localparam int WK    = 8;
  localparam int WY    = WX + WK + $clog2(C);
  localparam int BEATS = C / P;

  logic clk, rstn;

  logic                 s_valid, s_ready, s_signed, m_valid, m_ready;
  logic [R*P*WK-1:0]    s_k;
  logic [P*WX-1:0]      s_x;
  logic [R*WY-1:0]      m_y;

  logic                 s_valid2, s_ready2, s_signed2, m_valid2, m_ready2;
  logic [R*C*WK-1:0]    s_k2;
  logic [C*WX-1:0]      s_x2;
  logic [R*WY-1:0]      m_y2;

  int km [R][C];
  int xv [C];

  logic [R*WY-1:0] exp_q[$];
  logic [R*WY-1:0] exp_q2[$];
  logic [R*WY-1:0] pop1, pop2;

  int n_tests = 0;
  int n_fail  = 0;

  matvec_mul_fold #(.R(R), .C(C), .P(P), .W_X(WX), .W_K(WK)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_k(s_k), .s_x(s_x),
    .s_signed(s_signed), .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y)
  );

  matvec_mul_fold #(.R(R), .C(C), .P(C), .W_X(WX), .W_K(WK)) dut2 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid2), .s_ready(s_ready2), .s_k(s_k2), .s_x(s_x2),
    .s_signed(s_signed2), .m_valid(m_valid2), .m_ready(m_ready2), .m_y(m_y2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int elem(input int v, input bit sgn);
    logic [7:0] b;
    b = v[7:0];
    if (sgn) return $signed(b);
    return {24'b0, b};
  endfunction

  function automatic logic [R*WY-1:0] model(input bit sgn);
    logic [R*WY-1:0] y;
    longint acc;
    logic [63:0] a;
    y = '0;
    for (int r = 0; r < R; r++) begin
      acc = 0;
      for (int c = 0; c < C; c++)
        acc += longint'(elem(km[r][c], sgn)) * longint'(elem(xv[c], sgn));
      a = acc;
      y[r*WY +: WY] = a[WY-1:0];
    end
    return y;
  endfunction

  // Drives one beat of the folded instance; returns at posedge+1 after acceptance.
  task automatic drive_beat(input int b, input bit sgn);
    int kv, xw, n;
    bit acc;
    for (int r = 0; r < R; r++)
      for (int p = 0; p < P; p++) begin
        kv = km[r][b*P+p];
        s_k[(r*P+p)*WK +: WK] = kv[7:0];
      end
    for (int p = 0; p < P; p++) begin
      xw = xv[b*P+p];
      s_x[p*WX +: WX] = xw[7:0];
    end
    s_signed = sgn;
    s_valid  = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("beat_accept_timeout", '0, 256'(1));
  endtask

  task automatic send_vec(input bit sgn);
    exp_q.push_back(model(sgn));
    for (int b = 0; b < BEATS; b++) drive_beat(b, sgn);
    s_valid = 1'b0;
  endtask

  task automatic send2(input bit sgn);
    int kv, n;
    bit acc;
    exp_q2.push_back(model(sgn));
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        kv = km[r][c];
        s_k2[(r*C+c)*WK +: WK] = kv[7:0];
      end
    for (int c = 0; c < C; c++) begin
      kv = xv[c];
      s_x2[c*WX +: WX] = kv[7:0];
    end
    s_signed2 = sgn;
    s_valid2  = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = s_ready2;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("beat2_accept_timeout", '0, 256'(1));
    s_valid2 = 1'b0;
  endtask

  task automatic fill_random();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) km[r][c] = int'($urandom_range(0, 255));
    for (int c = 0; c < C; c++) xv[c] = int'($urandom_range(0, 255));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_q2.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 256'(exp_q.size() + exp_q2.size()), '0);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (m_valid && exp_q.size() == 0) begin
        check("spurious_valid", 256'(m_valid), '0);
      end else if (m_valid && !m_ready) begin
        check("stall_s_ready", 256'(s_ready), '0);
        check("stall_hold_y", 256'(m_y), 256'(exp_q[0]));
      end else if (m_valid && m_ready) begin
        pop1 = exp_q.pop_front();
        check("result_y", 256'(m_y), 256'(pop1));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && m_valid2) begin
      if (exp_q2.size() == 0) begin
        check("spurious_valid2", 256'(m_valid2), '0);
      end else if (m_ready2) begin
        pop2 = exp_q2.pop_front();
        check("result_y2", 256'(m_y2), 256'(pop2));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn = 1'b0;
    s_valid = 1'b0; s_k = '0; s_x = '0; s_signed = 1'b0; m_ready = 1'b1;
    s_valid2 = 1'b0; s_k2 = '0; s_x2 = '0; s_signed2 = 1'b0; m_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    @(negedge clk);
    check("reset_m_valid", 256'(m_valid), '0);
    check("reset_s_ready", 256'(s_ready), 256'(1));
    check("reset_m_y", 256'(m_y), '0);
    check("reset_m_valid2", 256'(m_valid2), '0);
    @(posedge clk); #1;

    // Signed, k[r][c]=r+1, x=1, two back-to-back beats, latency from the last beat.
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) km[r][c] = r + 1;
    for (int c = 0; c < C; c++) xv[c] = 1;
    send_vec(1'b1);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (m_valid) break;
      @(posedge clk); #1;
      n++;
    end
    check("latency_p4", 256'(n), 256'(4));
    @(posedge clk); #1;
    drain("drain_basic");

    // Signed extremes.
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) km[r][c] = -128;
    for (int c = 0; c < C; c++) xv[c] = -128;
    send_vec(1'b1);
    for (int c = 0; c < C; c++) xv[c] = 127;
    send_vec(1'b1);
    drain("drain_signed_ext");

    // Unsigned extremes.
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) km[r][c] = 255;
    for (int c = 0; c < C; c++) xv[c] = 255;
    send_vec(1'b0);
    drain("drain_unsigned_ext");

    // Three vectors with a 5-cycle downstream stall on result 0.
    m_ready = 1'b0;
    fork
      begin
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) km[r][c] = r - c;
        for (int c = 0; c < C; c++) xv[c] = c * 3 - 10;
        send_vec(1'b1);
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) km[r][c] = (r * c) % 17 - 8;
        for (int c = 0; c < C; c++) xv[c] = 5 - c;
        send_vec(1'b1);
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) km[r][c] = 100 - r * c;
        for (int c = 0; c < C; c++) xv[c] = c - 4;
        send_vec(1'b1);
      end
      begin
        int w;
        w = 0;
        while (w < 100) begin
          @(negedge clk);
          if (m_valid) break;
          w++;
        end
        check("stall_result_seen", 256'(m_valid), 256'(1));
        repeat (5) begin @(posedge clk); #1; end
        m_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Reset mid-vector, then a fresh vector must exclude the discarded beat.
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) km[r][c] = 7;
    for (int c = 0; c < C; c++) xv[c] = 3;
    drive_beat(0, 1'b0);
    s_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("midreset_m_valid", 256'(m_valid), '0);
    check("midreset_s_ready", 256'(s_ready), 256'(1));
    @(posedge clk); #1;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) km[r][c] = r + 2 * c;
    for (int c = 0; c < C; c++) xv[c] = c + 1;
    send_vec(1'b0);
    drain("drain_midreset");

    // Random mixed-mode vectors with input gaps and random backpressure.
    fork
      begin
        for (int v = 0; v < 6; v++) begin
          fill_random();
          send_vec(1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        repeat (60) begin
          m_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
    join
    drain("drain_random");

    // Single-beat configuration: latency, then one vector per cycle.
    fill_random();
    send2(1'b1);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (m_valid2) break;
      @(posedge clk); #1;
      n++;
    end
    check("latency_p8", 256'(n), 256'(5));
    @(posedge clk); #1;
    for (int v = 0; v < 20; v++) begin
      fill_random();
      send2(1'b1);
    end
    drain("drain_p8");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
